// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared phase encodings, screen geometry and helpers for the game controller
// Contents:
//   phase_t    game phase codes: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4
//   X_LIMIT    largest enemy x + 1 (SCREEN_W - ENEMY_SIZE)
//   Y_LIMIT    largest enemy y + 1 (SCREEN_H - ENEMY_SIZE)
//   LFSR_SEED  spawn LFSR value after reset
//   to_bcd     binary 0..99 to two packed BCD digits
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } phase_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int ENEMY_SIZE = 20;

    // An enemy sprite must fit entirely on screen, so its top-left corner
    // stays below these limits.
    localparam logic [9:0] X_LIMIT = 10'(SCREEN_W - ENEMY_SIZE);
    localparam logic [9:0] Y_LIMIT = 10'(SCREEN_H - ENEMY_SIZE);

    localparam logic [9:0] LFSR_SEED = 10'h280;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        return ((v / 8'd10) << 4) | (v % 8'd10);
    endfunction

endpackage

// File: rtl/wave_scheduler_if.sv
// rtl/wave_scheduler_if.sv - spawn request handshake between scheduler and enemy table
// Signals:
//   spawn_valid  scheduler -> table  spawn request pending
//   spawn_slot   scheduler -> table  slot index to fill
//   spawn_x      scheduler -> table  enemy x, 0..619
//   spawn_y      scheduler -> table  enemy y, 0..459
//   spawn_ack    table -> scheduler  request accepted
// Modports: master (scheduler side), slave (enemy table side).
interface wave_scheduler_if;

    logic       spawn_valid;
    logic [3:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic       spawn_ack;

    modport master (
        output spawn_valid,
        output spawn_slot,
        output spawn_x,
        output spawn_y,
        input  spawn_ack
    );

    modport slave (
        input  spawn_valid,
        input  spawn_slot,
        input  spawn_x,
        input  spawn_y,
        output spawn_ack
    );

endinterface

// File: rtl/spawn_lfsr.sv
// rtl/spawn_lfsr.sv - 10-bit Galois LFSR (x^10+x^7+1) folded into on-screen spawn coordinates
// Ports:
//   clk_1Hz  in   game tick clock
//   rst      in   asynchronous, active-high reset (loads LFSR_SEED)
//   en       in   advance the LFSR on this tick
//   x        out  lfsr folded into 0..X_LIMIT-1
//   y        out  rotated lfsr folded into 0..Y_LIMIT-1
module spawn_lfsr
    import game_pkg::*;
(
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] x,
    output logic [9:0] y
);

    logic [9:0] lfsr;
    logic [9:0] rot;
    logic [9:0] y_once;

    // Right-shifting Galois form: the bit shifted out toggles the x^10 and
    // x^7 taps. A nonzero seed can never reach the all-zero state.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[9:1]} ^ (lfsr[0] ? 10'h240 : 10'h000);
        end
    end

    // lfsr < 1024 < 2*620, so one conditional subtraction suffices for x.
    assign x = (lfsr < X_LIMIT) ? lfsr : lfsr - X_LIMIT;

    // Rotating decorrelates y from x; 1023 < 3*460 needs two subtractions.
    assign rot    = {lfsr[4:0], lfsr[9:5]};
    assign y_once = (rot >= Y_LIMIT) ? rot - Y_LIMIT : rot;
    assign y      = (y_once >= Y_LIMIT) ? y_once - Y_LIMIT : y_once;

endmodule

// File: rtl/wave_scheduler.sv
// rtl/wave_scheduler.sv - game phase FSM, round timer and enemy spawn scheduler
// Ports:
//   clk_1Hz      in   game tick clock
//   rst          in   asynchronous, active-high reset
//   start        in   level; rising edge starts a round from IDLE or OVER
//   pause        in   level; high pauses PLAY
//   score        in   current score 0..99
//   slot_active  in   occupancy of each enemy table slot
//   spawn_bus    master side of the spawn valid/ack handshake
//   state        out  phase code (game_pkg::phase_t)
//   time_left    out  remaining ticks in the current phase
//   time_bcd     out  time_left as two BCD digits
//   level        out  difficulty level min(score/LEVEL_STEP, 7)
//   clear_all    out  one-tick pulse to clear the enemy table
module wave_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS         = 10,
    parameter int ROUND_SECONDS     = 60,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int BASE_INTERVAL     = 4,
    parameter int MIN_INTERVAL      = 1,
    parameter int LEVEL_STEP        = 10
) (
    input  logic                 clk_1Hz,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic [7:0]           score,
    input  logic [NUM_SLOTS-1:0] slot_active,
    wave_scheduler_if.master     spawn_bus,
    output logic [2:0]           state,
    output logic [7:0]           time_left,
    output logic [7:0]           time_bcd,
    output logic [2:0]           level,
    output logic                 clear_all
);

    phase_t     state_q, state_d;
    logic [7:0] time_d;
    logic [2:0] level_d;
    logic       clear_d;
    logic       start_q;
    logic [7:0] ctr_q, ctr_d;
    logic       valid_q, valid_d;
    logic [3:0] slot_q, slot_d;
    logic [9:0] x_q, x_d, y_q, y_d;

    logic [9:0] lfsr_x, lfsr_y;
    logic       lfsr_en;
    logic       start_rise;
    logic       ack;
    logic [7:0] score_level;
    logic [7:0] interval;
    logic [7:0] ctr_inc;
    logic [7:0] ctr_sat;
    logic       free_found;
    logic [3:0] free_slot;

    assign start_rise = start & ~start_q;
    assign ack        = valid_q & spawn_bus.spawn_ack;
    assign lfsr_en    = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY);

    spawn_lfsr u_lfsr (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .en      (lfsr_en),
        .x       (lfsr_x),
        .y       (lfsr_y)
    );

    assign score_level = score / 8'(LEVEL_STEP);
    assign level_d     = (score_level > 8'd7) ? 3'd7 : score_level[2:0];

    // Saturating BASE_INTERVAL - level, floored at MIN_INTERVAL.
    always_comb begin
        if (8'(BASE_INTERVAL) >= 8'(MIN_INTERVAL) + 8'(level)) begin
            interval = 8'(BASE_INTERVAL) - 8'(level);
        end else begin
            interval = 8'(MIN_INTERVAL);
        end
    end

    assign ctr_inc = ctr_q + 8'd1;
    assign ctr_sat = (ctr_inc > interval) ? interval : ctr_inc;

    // Lowest free slot wins: scanning downward lets the lowest index overwrite.
    always_comb begin
        free_found = 1'b0;
        free_slot  = 4'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_found = 1'b1;
                free_slot  = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_left;
        ctr_d   = ctr_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        x_d     = x_q;
        y_d     = y_q;
        clear_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                valid_d = 1'b0;
                if (start_rise) begin
                    state_d = ST_COUNTDOWN;
                    time_d  = 8'(COUNTDOWN_SECONDS);
                    clear_d = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (time_left == 8'd1) begin
                    state_d = ST_PLAY;
                    time_d  = 8'(ROUND_SECONDS);
                    ctr_d   = 8'd0;
                end else begin
                    time_d = time_left - 8'd1;
                end
            end
            ST_PLAY: begin
                if (ack) begin
                    valid_d = 1'b0;
                end
                if (time_left == 8'd1) begin
                    state_d = ST_OVER;
                    time_d  = 8'd0;
                    valid_d = 1'b0;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    time_d = time_left - 8'd1;
                    // valid_q (not valid_d) gates issue, so an acked spawn
                    // leaves a one-tick gap before the next one.
                    if (!valid_q && ctr_inc >= interval && free_found) begin
                        valid_d = 1'b1;
                        ctr_d   = 8'd0;
                        slot_d  = free_slot;
                        x_d     = lfsr_x;
                        y_d     = lfsr_y;
                    end else begin
                        ctr_d = ctr_sat;
                    end
                end
            end
            ST_PAUSE: begin
                if (ack) begin
                    valid_d = 1'b0;
                end
                if (!pause) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            time_left <= 8'd0;
            level     <= 3'd0;
            clear_all <= 1'b0;
            start_q   <= 1'b0;
            ctr_q     <= 8'd0;
            valid_q   <= 1'b0;
            slot_q    <= 4'd0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
        end else begin
            state_q   <= state_d;
            time_left <= time_d;
            level     <= level_d;
            clear_all <= clear_d;
            start_q   <= start;
            ctr_q     <= ctr_d;
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign state                 = state_q;
    assign time_bcd              = to_bcd(time_left);
    assign spawn_bus.spawn_valid = valid_q;
    assign spawn_bus.spawn_slot  = slot_q;
    assign spawn_bus.spawn_x     = x_q;
    assign spawn_bus.spawn_y     = y_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// tb/tb_wave_scheduler.sv - directed self-checking bench for wave_scheduler
module tb_wave_scheduler;

    logic       clk_1Hz = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] score = 8'd0;
    logic [9:0] slot_active = 10'd0;
    logic [2:0] state;
    logic [7:0] time_left;
    logic [7:0] time_bcd;
    logic [2:0] level;
    logic       clear_all;

    int total = 0;
    int bad = 0;

    logic [3:0] exp_q[$];
    logic [9:0] m_lfsr;
    logic [9:0] m_rot;
    logic [9:0] ex;
    logic [9:0] ey;

    wave_scheduler_if bus();

    wave_scheduler #(
        .NUM_SLOTS         (10),
        .ROUND_SECONDS     (60),
        .COUNTDOWN_SECONDS (3),
        .BASE_INTERVAL     (4),
        .MIN_INTERVAL      (1),
        .LEVEL_STEP        (10)
    ) dut (
        .clk_1Hz     (clk_1Hz),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .score       (score),
        .slot_active (slot_active),
        .spawn_bus   (bus),
        .state       (state),
        .time_left   (time_left),
        .time_bcd    (time_bcd),
        .level       (level),
        .clear_all   (clear_all)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_1Hz);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_1Hz);
    endtask

    // Called when the DUT presents a new spawn: pop the expected slot.
    task automatic sb_pop(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_slot"}, 32'(bus.spawn_slot), 32'(e));
            chk({tag, "_x_range"}, 32'(bus.spawn_x < 10'd620), 32'd1);
            chk({tag, "_y_range"}, 32'(bus.spawn_y < 10'd460), 32'd1);
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        return {1'b0, v[9:1]} ^ (v[0] ? 10'h240 : 10'h000);
    endfunction

    initial begin
        bus.spawn_ack = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(bus.spawn_valid), 32'd0);
        chk("rst_slot", 32'(bus.spawn_slot), 32'd0);
        chk("rst_x", 32'(bus.spawn_x), 32'd0);
        chk("rst_y", 32'(bus.spawn_y), 32'd0);
        chk("rst_time", 32'(time_left), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_clear", 32'(clear_all), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(state), 32'd0);

        // Phase entry
        start = 1'b1;
        tick();
        chk("cd_state", 32'(state), 32'd1);
        chk("cd_time3", 32'(time_left), 32'd3);
        chk("cd_bcd3", 32'(time_bcd), 32'h03);
        chk("cd_clear_on", 32'(clear_all), 32'd1);
        start = 1'b0;
        tick();
        chk("cd_time2", 32'(time_left), 32'd2);
        chk("cd_clear_off", 32'(clear_all), 32'd0);
        tick();
        chk("cd_time1", 32'(time_left), 32'd1);
        tick();
        chk("play_state", 32'(state), 32'd2);
        chk("play_time60", 32'(time_left), 32'd60);
        chk("play_bcd60", 32'(time_bcd), 32'h60);

        // First spawn: coordinates come from the LFSR after 3 countdown + 3 play steps
        m_lfsr = 10'h280;
        repeat (6) m_lfsr = lfsr_step(m_lfsr);
        ex = (m_lfsr < 10'd620) ? m_lfsr : m_lfsr - 10'd620;
        m_rot = {m_lfsr[4:0], m_lfsr[9:5]};
        ey = m_rot % 10'd460;
        exp_q.push_back(4'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("first_valid", 32'(bus.spawn_valid), 32'(i == 4));
        end
        sb_pop("first");
        chk("first_x", 32'(bus.spawn_x), 32'(ex));
        chk("first_y", 32'(bus.spawn_y), 32'(ey));
        chk("first_time", 32'(time_left), 32'd56);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(bus.spawn_valid), 32'd1);
            chk("hold_slot", 32'(bus.spawn_slot), 32'd0);
            chk("hold_x", 32'(bus.spawn_x), 32'(ex));
            chk("hold_y", 32'(bus.spawn_y), 32'(ey));
        end

        // Ack, then allocation with slots 0..2 busy
        bus.spawn_ack = 1'b1;
        slot_active = 10'b0000000111;
        exp_q.push_back(4'd3);
        tick();
        chk("ack_clears", 32'(bus.spawn_valid), 32'd0);
        bus.spawn_ack = 1'b0;
        tick();
        chk("alloc3_valid", 32'(bus.spawn_valid), 32'd1);
        if (bus.spawn_valid) sb_pop("alloc3");

        // All slots busy: nothing for 10 ticks, then slot 5 frees
        bus.spawn_ack = 1'b1;
        slot_active = 10'h3FF;
        tick();
        chk("full_ack", 32'(bus.spawn_valid), 32'd0);
        bus.spawn_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_no_spawn", 32'(bus.spawn_valid), 32'd0);
        end
        slot_active = 10'h3DF;
        exp_q.push_back(4'd5);
        tick();
        chk("free5_valid", 32'(bus.spawn_valid), 32'd1);
        if (bus.spawn_valid) sb_pop("free5");
        chk("free5_time", 32'(time_left), 32'd39);

        // Level 2: interval 2, with ack always high a spawn appears every other tick
        bus.spawn_ack = 1'b1;
        score = 8'd25;
        slot_active = 10'd0;
        tick();
        chk("lvl2_ack", 32'(bus.spawn_valid), 32'd0);
        chk("lvl2_level", 32'(level), 32'd2);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) exp_q.push_back(4'd0);
            tick();
            chk("lvl2_valid", 32'(bus.spawn_valid), 32'(k % 2 == 0));
            if (bus.spawn_valid) sb_pop("lvl2");
        end

        // Level 7: interval saturates at 1
        score = 8'd99;
        exp_q.push_back(4'd0);
        tick();
        chk("lvl7_level", 32'(level), 32'd7);
        chk("lvl7_first", 32'(bus.spawn_valid), 32'd1);
        if (bus.spawn_valid) sb_pop("lvl7a");
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 1) exp_q.push_back(4'd0);
            tick();
            chk("lvl7_valid", 32'(bus.spawn_valid), 32'(k % 2 == 1));
            if (bus.spawn_valid) sb_pop("lvl7");
        end
        chk("lvl7_time", 32'(time_left), 32'd25);

        // Pause for 5 ticks with a spawn pending
        bus.spawn_ack = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause_state", 32'(state), 32'd3);
            chk("pause_time", 32'(time_left), 32'd25);
            chk("pause_bcd", 32'(time_bcd), 32'h25);
            chk("pause_valid", 32'(bus.spawn_valid), 32'd1);
        end
        pause = 1'b0;
        tick();
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_time", 32'(time_left), 32'd25);
        ticks(24);
        chk("last_tick_time", 32'(time_left), 32'd1);
        chk("last_tick_state", 32'(state), 32'd2);
        tick();
        chk("over_state", 32'(state), 32'd4);
        chk("over_valid", 32'(bus.spawn_valid), 32'd0);
        chk("over_time", 32'(time_left), 32'd0);
        chk("over_bcd", 32'(time_bcd), 32'h00);

        // Restart from OVER, start ignored in PLAY, pause on the final tick
        start = 1'b1;
        tick();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_clear", 32'(clear_all), 32'd1);
        chk("restart_time", 32'(time_left), 32'd3);
        ticks(3);
        chk("r2_play", 32'(state), 32'd2);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("r2_start_ignored", 32'(state), 32'd2);
        chk("r2_no_clear", 32'(clear_all), 32'd0);
        chk("r2_time", 32'(time_left), 32'd58);
        ticks(57);
        chk("r2_time1", 32'(time_left), 32'd1);
        chk("r2_bcd1", 32'(time_bcd), 32'h01);
        pause = 1'b1;
        tick();
        chk("r2_timeout_over_pause", 32'(state), 32'd4);
        chk("r2_valid", 32'(bus.spawn_valid), 32'd0);
        pause = 1'b0;

        // Third round: reset while a spawn is pending
        start = 1'b0;
        score = 8'd0;
        tick();
        start = 1'b1;
        tick();
        chk("r3_state", 32'(state), 32'd1);
        ticks(3);
        ticks(4);
        chk("r3_valid", 32'(bus.spawn_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_valid", 32'(bus.spawn_valid), 32'd0);
        chk("arst_slot", 32'(bus.spawn_slot), 32'd0);
        chk("arst_x", 32'(bus.spawn_x), 32'd0);
        chk("arst_y", 32'(bus.spawn_y), 32'd0);
        chk("arst_time", 32'(time_left), 32'd0);
        chk("arst_bcd", 32'(time_bcd), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_clear", 32'(clear_all), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_scheduler.md
Name: wave_scheduler

Overview:
- Game-phase controller and enemy-spawn scheduler for the shooter datapath, running on the 1 Hz game tick.
- Sequences IDLE / COUNTDOWN / PLAY / PAUSE / OVER.
- Owns the round timer and the spawn LFSR.
- Allocates free enemy slots and issues one spawn at a time, with on-screen coordinates, to the enemy table over a valid/ack handshake. The spawn rate increases with score.

Parameters:
- NUM_SLOTS, 10, number of enemy table slots (max 16).
- ROUND_SECONDS, 60, PLAY duration in ticks (1..99).
- COUNTDOWN_SECONDS, 3, COUNTDOWN duration in ticks (1..99).
- BASE_INTERVAL, 4, spawn interval in ticks at level 0.
- MIN_INTERVAL, 1, floor on the spawn interval.
- LEVEL_STEP, 10, score points per level.

Ports:
- clk_1Hz  in  1  game tick clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; rising edge is detected internally.
- pause  in  1  level; high requests pause.
- score  in  8  current score, binary 0..99.
- slot_active  in  NUM_SLOTS  bit i is high when enemy slot i is occupied.
- spawn_ack  in  1  enemy table accepted the spawn.
- spawn_valid  out  1  spawn request pending.
- spawn_slot  out  4  slot index to fill.
- spawn_x  out  10  enemy x, range 0..619.
- spawn_y  out  10  enemy y, range 0..459.
- state  out  3  phase code: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4.
- time_left  out  8  remaining ticks in the current phase, binary.
- time_bcd  out  8  time_left as two BCD digits for the seven-segment display.
- level  out  3  current difficulty level.
- clear_all  out  1  one-tick pulse telling the enemy table to clear all slots.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk_1Hz. All state changes on the posedge of clk_1Hz.
- Reset values:
  - state=IDLE; spawn_valid=0; spawn_slot=0; spawn_x=0; spawn_y=0; time_left=0; level=0; clear_all=0.
  - start-edge register=0; interval counter=0; LFSR=10'h280.
  - Reset mid-round aborts everything immediately; any pending spawn is dropped.
- Start edge: start_rise = start & ~start_q; start_q is registered every tick.
- IDLE:
  - start_rise -> COUNTDOWN; time_left<=COUNTDOWN_SECONDS; clear_all<=1 for exactly one tick.
- COUNTDOWN:
  - If time_left==1 -> PLAY; time_left<=ROUND_SECONDS; interval counter<=0.
  - Otherwise time_left decrements.
  - COUNTDOWN lasts exactly COUNTDOWN_SECONDS ticks.
- PLAY:
  - If time_left==1 -> OVER; time_left<=0; spawn_valid<=0. Timeout has priority over pause on the same tick.
  - Else if pause -> PAUSE.
  - Else time_left decrements.
  - PLAY lasts exactly ROUND_SECONDS unpaused ticks.
- PAUSE:
  - Timer, interval counter and LFSR frozen. spawn_valid and its payload are held; ack is still honoured.
  - pause low -> PLAY.
- OVER:
  - spawn_valid=0. start_rise -> COUNTDOWN, same as from IDLE, including the clear_all pulse.
- start_rise is ignored in COUNTDOWN, PLAY and PAUSE.
- level = min(score / LEVEL_STEP, 7), registered every tick in every state.
- interval = max(BASE_INTERVAL - level, MIN_INTERVAL). Use saturating subtraction; no underflow.
- Spawn scheduling (PLAY only, when not timing out):
  - Each tick: if !spawn_valid and counter+1 >= interval and slot_active is not all ones:
    - spawn_valid<=1 and counter<=0.
    - spawn_slot<=lowest index i with slot_active[i]==0.
    - spawn_x and spawn_y are taken from the current LFSR value.
  - Else counter<=min(counter+1, interval), i.e. it saturates while all slots are full or a spawn is pending.
  - A slot freeing up while the counter is saturated produces spawn_valid on the next tick.
- Handshake:
  - spawn_valid, spawn_slot, spawn_x and spawn_y are stable until spawn_ack is sampled high while spawn_valid=1.
  - On that tick spawn_valid<=0. A new spawn can be issued no earlier than the following tick.
  - spawn_ack while spawn_valid=0 is ignored.
- LFSR:
  - Galois, polynomial x^10+x^7+1. Steps every tick in COUNTDOWN and PLAY; frozen in other states. Never all zero.
  - spawn_x = lfsr<620 ? lfsr : lfsr-620.
  - Let r = {lfsr[4:0], lfsr[9:5]}. spawn_y = r mod 460, computed by two conditional subtractions.
- time_bcd is combinational from time_left: tens digit in [7:4], units in [3:0].

Decomposition:
- Shared package game_pkg:
  - State encodings.
  - SCREEN_W=640, SCREEN_H=480, ENEMY_SIZE=20, and the derived limits 620 and 460.
  - LFSR seed.
- One sub-module, spawn_lfsr: 10-bit Galois LFSR with an enable input and the coordinate folding logic.
- Slot allocation (priority encoder) and the FSM stay in wave_scheduler.

Test Plan:
- Phase entry: reset, pulse start -> clear_all high for 1 tick; state=1 with time_left 3,2,1; then state=2 with time_left=60.
- First spawn and handshake: score=0, slot_active=0 -> spawn_valid rises on the 4th tick after entering PLAY with spawn_slot=0, spawn_x<620, spawn_y<460. Hold spawn_ack=0 for 3 ticks -> payload unchanged. Raise ack -> spawn_valid=0 on the next tick.
- Slot allocation: slot_active=10'b0000000111 -> spawn_slot=3. slot_active=all ones -> no spawn for 10 ticks. Clear bit 5 -> spawn_valid on the next tick with spawn_slot=5.
- Level scaling: score=25 -> level=2, spawns every 2 ticks. score=99 -> level=7, interval=1.
- Pause and timeout: pause for 5 ticks -> time_left frozen and spawn_valid held. After resume, 60 total PLAY ticks -> state=4 and spawn_valid=0. Pause asserted on the tick where time_left==1 -> state=4. start in OVER -> COUNTDOWN with a clear_all pulse.
- Reset mid-operation: assert rst while spawn_valid=1 in PLAY -> all outputs go to their reset values immediately, without waiting for a clock edge.
